// File: rtl/work_packet_tx.sv
// work_packet_tx: frames one 672-bit work unit as 84 bytes of 8N1 UART.
// Ports: clk, rst_n (async low); pkt_valid/pkt_ready accept handshake;
//   pkt_data[607:0], pkt_nonce[31:0], pkt_target1[31:0] packet fields;
//   TxD serial line (idle high, registered); busy while sending;
//   byte_done pulses at end of each stop bit; pkt_done at packet end.
module work_packet_tx #(
  parameter int BAUD_DIV  = 434,
  parameter int PKT_BYTES = 84,
  parameter int GAP_BITS  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pkt_valid,
  output logic         pkt_ready,
  input  logic [607:0] pkt_data,
  input  logic [31:0]  pkt_nonce,
  input  logic [31:0]  pkt_target1,
  output logic         TxD,
  output logic         busy,
  output logic         byte_done,
  output logic         pkt_done
);

  localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [6:0]  BYTE_LAST = 7'(PKT_BYTES - 1);
  localparam logic [3:0]  GAP_LAST  =
    (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [6:0]    byte_cnt_q, byte_cnt_d;
  logic [671:0]  pkt_q, pkt_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          tick;
  logic          next_byte;
  logic          last_byte;

  assign tick      = (div_q == 16'd0);
  assign last_byte = (byte_cnt_q == BYTE_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    pkt_d      = pkt_q;
    sh_d       = sh_q;
    txd_d      = txd_q;
    byte_done  = 1'b0;
    pkt_done   = 1'b0;
    next_byte  = 1'b0;

    // divider reloads at every bit boundary
    if (state_q != S_IDLE) begin
      div_d = tick ? DIV_LAST : div_q - 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          state_d    = S_START;
          div_d      = DIV_LAST;
          byte_cnt_d = 7'd0;
          pkt_d      = {pkt_data, pkt_nonce, pkt_target1};
          sh_d       = pkt_data[607:600];
          txd_d      = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 4'd0;
          txd_d   = sh_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 4'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          byte_done = 1'b1;
          if (GAP_BITS > 0) begin
            state_d = S_GAP;
            bit_d   = 4'd0;
          end else begin
            next_byte = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (bit_q == GAP_LAST) begin
            next_byte = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (next_byte) begin
      if (last_byte) begin
        state_d  = S_IDLE;
        pkt_done = 1'b1;
        txd_d    = 1'b1;
      end else begin
        state_d    = S_START;
        byte_cnt_d = byte_cnt_q + 7'd1;
        pkt_d      = pkt_q << 8;
        sh_d       = pkt_q[663:656];
        txd_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_q      <= 16'd0;
      bit_q      <= 4'd0;
      byte_cnt_q <= 7'd0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      txd_q      <= txd_d;
    end
  end

  // payload shifters need no reset: contents are reloaded on accept
  always_ff @(posedge clk) begin
    pkt_q <= pkt_d;
    sh_q  <= sh_d;
  end

  assign TxD       = txd_q;
  assign busy      = (state_q != S_IDLE);
  assign pkt_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_work_packet_tx.sv
// tb_work_packet_tx: randomized packets on two work_packet_tx instances,
// decoded by a behavioural UART receiver and compared to field layout.
module tb_work_packet_tx;

  localparam int BAUD = 4;
  localparam int NB   = 84;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         a_valid = 0, b_valid = 0;
  logic [607:0] a_data = '0, b_data = '0;
  logic [31:0]  a_nonce = '0, b_nonce = '0;
  logic [31:0]  a_tgt = '0, b_tgt = '0;
  logic a_ready, a_txd, a_busy, a_bd, a_pd;
  logic b_ready, b_txd, b_busy, b_bd, b_pd;

  work_packet_tx #(.BAUD_DIV(BAUD), .PKT_BYTES(NB), .GAP_BITS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .pkt_valid(a_valid), .pkt_ready(a_ready),
    .pkt_data(a_data), .pkt_nonce(a_nonce), .pkt_target1(a_tgt),
    .TxD(a_txd), .busy(a_busy), .byte_done(a_bd), .pkt_done(a_pd));

  work_packet_tx #(.BAUD_DIV(BAUD), .PKT_BYTES(NB), .GAP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pkt_valid(b_valid), .pkt_ready(b_ready),
    .pkt_data(b_data), .pkt_nonce(b_nonce), .pkt_target1(b_tgt),
    .TxD(b_txd), .busy(b_busy), .byte_done(b_bd), .pkt_done(b_pd));

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int frame_err = 0;
  int bd_a = 0, pd_a = 0, pdc_a = 0;
  int bd_b = 0, pd_b = 0, pdc_b = 0;
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  int st_a[$];
  int st_b[$];
  bit hist_b[int];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_bd) bd_a++;
    if (a_pd) begin pd_a++; pdc_a = cyc; end
    if (b_bd) bd_b++;
    if (b_pd) begin pd_b++; pdc_b = cyc; end
    hist_b[cyc] = b_txd;
  end

  function automatic logic line(input int sel);
    return (sel != 0) ? b_txd : a_txd;
  endfunction

  // behavioural 8N1 receiver, samples mid-bit
  task automatic decode(input int sel);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (line(sel) === 1'b0) begin
        if (sel != 0) st_b.push_back(cyc);
        else st_a.push_back(cyc);
        repeat (BAUD / 2) @(negedge clk);
        if (line(sel) !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = line(sel);
        end
        repeat (BAUD) @(negedge clk);
        if (line(sel) !== 1'b1) frame_err++;
        if (sel != 0) rx_b.push_back(b);
        else rx_a.push_back(b);
      end
    end
  endtask

  initial decode(0);
  initial decode(1);

  function automatic logic [671:0] rand_pkt();
    logic [671:0] v;
    for (int i = 0; i < 21; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [671:0] v,
                                          input int i);
    return v[671 - 8*i -: 8];
  endfunction

  function automatic int stream_bad(input int sel, input logic [671:0] v,
                                    input int base);
    int n = 0;
    int sz;
    logic [7:0] g;
    sz = (sel != 0) ? rx_b.size() : rx_a.size();
    for (int i = 0; i < NB; i++) begin
      if (base + i >= sz) n++;
      else begin
        g = (sel != 0) ? rx_b[base+i] : rx_a[base+i];
        if (g !== exp_byte(v, i)) n++;
      end
    end
    return n;
  endfunction

  task automatic set_fields(input int sel, input logic [671:0] v);
    if (sel != 0) begin
      b_data = v[671:64]; b_nonce = v[63:32]; b_tgt = v[31:0];
    end else begin
      a_data = v[671:64]; a_nonce = v[63:32]; a_tgt = v[31:0];
    end
  endtask

  // returns label of the first start-bit cycle
  task automatic offer(input int sel, input logic [671:0] v,
                       input bit hold, output int s);
    int k = 0;
    @(negedge clk);
    set_fields(sel, v);
    if (sel != 0) b_valid = 1; else a_valid = 1;
    while (!((sel != 0) ? b_ready : a_ready) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    s = cyc;
    if (!hold) begin
      if (sel != 0) b_valid = 0; else a_valid = 0;
    end
  endtask

  task automatic wait_pd(input int sel, input int n, output bit ok);
    int k = 0;
    while (((sel != 0) ? pd_b : pd_a) < n && k < 10000) begin
      @(negedge clk);
      k++;
    end
    ok = (((sel != 0) ? pd_b : pd_a) >= n);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    #3 rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_txd, a_busy, a_ready, a_bd, a_pd} !== 5'b10100) begin
      fails++;
      $display("FAIL reset_a got=%b exp=10100",
               {a_txd, a_busy, a_ready, a_bd, a_pd});
    end
    checks++;
    if ({b_txd, b_busy, b_ready, b_bd, b_pd} !== 5'b10100) begin
      fails++;
      $display("FAIL reset_b got=%b exp=10100",
               {b_txd, b_busy, b_ready, b_bd, b_pd});
    end
    rst_n = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    logic [671:0] v;
    int s, bd0, pd0, bad;
    bit ok;
    for (int i = 0; i < 76; i++) v[671 - 8*i -: 8] = 8'(i + 1);
    v[63:0] = 64'hDEADBEEF_0000FFFF;
    rx_a.delete();
    bd0 = bd_a; pd0 = pd_a;
    offer(0, v, 0, s);
    checks++;
    if (a_txd !== 1'b0 || a_busy !== 1'b1) begin
      fails++;
      $display("FAIL single_start txd=%b busy=%b exp txd=0 busy=1",
               a_txd, a_busy);
    end
    wait_pd(0, pd0 + 1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL single_timeout no pkt_done"); end
    checks++;
    if (pdc_a - s + 1 !== NB * 10 * BAUD) begin
      fails++;
      $display("FAIL single_len got=%0d exp=%0d", pdc_a - s + 1,
               NB * 10 * BAUD);
    end
    checks++;
    if (rx_a.size() !== NB) begin
      fails++;
      $display("FAIL single_count got=%0d exp=%0d", rx_a.size(), NB);
    end
    bad = stream_bad(0, v, 0);
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL single_bytes bad=%0d exp=0", bad);
    end
    checks++;
    if (bd_a - bd0 !== NB || pd_a - pd0 !== 1) begin
      fails++;
      $display("FAIL single_pulses byte_done=%0d pkt_done=%0d exp 84/1",
               bd_a - bd0, pd_a - pd0);
    end
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL single_idle ready=%b busy=%b exp 1/0",
               a_ready, a_busy);
    end
  endtask

  task automatic test_bit_timing();
    logic [671:0] v;
    logic [9:0] frame;
    logic e;
    int s, pd0, bad;
    bit ok;
    v = rand_pkt();
    v[671:664] = 8'hA5;
    frame = {1'b1, v[671:664], 1'b0};
    rx_a.delete();
    pd0 = pd_a;
    offer(0, v, 0, s);
    for (int i = 0; i < 40; i++) begin
      e = frame[i / BAUD];
      checks++;
      if (a_txd !== e) begin
        fails++;
        $display("FAIL bit_timing clk=%0d got=%b exp=%b", i, a_txd, e);
      end
      @(negedge clk);
    end
    wait_pd(0, pd0 + 1, ok);
    bad = stream_bad(0, v, 0);
    checks++;
    if (!ok || bad !== 0) begin
      fails++;
      $display("FAIL bit_timing_bytes done=%0b bad=%0d exp 1/0", ok, bad);
    end
  endtask

  task automatic test_handshake();
    logic [671:0] v1, v2;
    int s, d, pd0, bad1, bad2, k;
    bit ok;
    v1 = rand_pkt();
    v2 = rand_pkt();
    v2[63:32] = 32'h00000001;
    rx_a.delete();
    st_a.delete();
    pd0 = pd_a;
    offer(0, v1, 1, s);
    set_fields(0, v2);
    d = s + NB * 10 * BAUD - 1;
    k = 0;
    while (cyc < d + 1 && k < 10000) begin @(negedge clk); k++; end
    checks++;
    if (a_ready !== 1'b1 || pdc_a !== d) begin
      fails++;
      $display("FAIL hs_ready ready=%b done_cyc=%0d exp 1/%0d",
               a_ready, pdc_a, d);
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || a_busy !== 1'b1 || a_txd !== 1'b0) begin
      fails++;
      $display("FAIL hs_accept ready=%b busy=%b txd=%b exp 0/1/0",
               a_ready, a_busy, a_txd);
    end
    a_valid = 0;
    wait_pd(0, pd0 + 2, ok);
    bad1 = stream_bad(0, v1, 0);
    bad2 = stream_bad(0, v2, NB);
    checks++;
    if (!ok || bad1 !== 0) begin
      fails++;
      $display("FAIL hs_first done=%0b bad=%0d exp 1/0", ok, bad1);
    end
    checks++;
    if (bad2 !== 0 || rx_a.size() !== 2 * NB) begin
      fails++;
      $display("FAIL hs_second bad=%0d size=%0d exp 0/%0d",
               bad2, rx_a.size(), 2 * NB);
    end
    checks++;
    if (st_a.size() <= NB || st_a[NB] !== d + 2) begin
      fails++;
      $display("FAIL hs_start2 got=%0d exp=%0d",
               (st_a.size() > NB) ? st_a[NB] : -1, d + 2);
    end
  endtask

  task automatic test_gap();
    logic [671:0] v;
    int s, pd0, bd0, bad, gap_bad, sp_bad, t;
    bit ok;
    v = rand_pkt();
    rx_b.delete();
    st_b.delete();
    hist_b.delete();
    pd0 = pd_b; bd0 = bd_b;
    offer(1, v, 0, s);
    wait_pd(1, pd0 + 1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL gap_timeout no pkt_done"); end
    checks++;
    if (pdc_b - s + 1 !== NB * 12 * BAUD) begin
      fails++;
      $display("FAIL gap_len got=%0d exp=%0d", pdc_b - s + 1,
               NB * 12 * BAUD);
    end
    bad = stream_bad(1, v, 0);
    checks++;
    if (bad !== 0 || rx_b.size() !== NB) begin
      fails++;
      $display("FAIL gap_bytes bad=%0d size=%0d exp 0/%0d",
               bad, rx_b.size(), NB);
    end
    checks++;
    if (bd_b - bd0 !== NB || pd_b - pd0 !== 1) begin
      fails++;
      $display("FAIL gap_pulses byte_done=%0d pkt_done=%0d exp 84/1",
               bd_b - bd0, pd_b - pd0);
    end
    gap_bad = 0;
    sp_bad = 0;
    for (int k = 0; k < NB; k++) begin
      t = s + k * 12 * BAUD;
      if (k >= st_b.size() || st_b[k] !== t) sp_bad++;
      for (int j = 0; j < 8; j++) begin
        if (!hist_b.exists(t + 10*BAUD + j) ||
            hist_b[t + 10*BAUD + j] !== 1'b1) gap_bad++;
      end
    end
    checks++;
    if (gap_bad !== 0) begin
      fails++;
      $display("FAIL gap_level low_clocks=%0d exp=0", gap_bad);
    end
    checks++;
    if (sp_bad !== 0) begin
      fails++;
      $display("FAIL gap_spacing bad_starts=%0d exp=0", sp_bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [671:0] v, v2;
    int s, pd0, bad, k;
    bit ok;
    v = rand_pkt();
    v2 = rand_pkt();
    offer(0, v, 0, s);
    k = 0;
    while (cyc < s + 10 * 10 * BAUD + BAUD + 6 && k < 10000) begin
      @(negedge clk);
      k++;
    end
    pd0 = pd_a;
    rst_n = 0;
    #1;
    checks++;
    if (a_txd !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_async txd=%b busy=%b ready=%b exp 1/0/1",
               a_txd, a_busy, a_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (60) @(negedge clk);
    checks++;
    if (pd_a !== pd0) begin
      fails++;
      $display("FAIL rst_mid_nodone pkt_done=%0d exp=0", pd_a - pd0);
    end
    rx_a.delete();
    offer(0, v2, 0, s);
    wait_pd(0, pd0 + 1, ok);
    bad = stream_bad(0, v2, 0);
    checks++;
    if (!ok || bad !== 0 || rx_a.size() !== NB) begin
      fails++;
      $display("FAIL rst_mid_resend done=%0b bad=%0d size=%0d exp 1/0/%0d",
               ok, bad, rx_a.size(), NB);
    end
  endtask

  task automatic test_loopback();
    logic [671:0] v, got;
    int s, pd0;
    bit ok;
    for (int p = 0; p < 2; p++) begin
      v = rand_pkt();
      rx_a.delete();
      pd0 = pd_a;
      offer(0, v, 0, s);
      wait_pd(0, pd0 + 1, ok);
      got = '0;
      for (int i = 0; i < NB && i < rx_a.size(); i++)
        got[671 - 8*i -: 8] = rx_a[i];
      checks++;
      if (!ok || pd_a - pd0 !== 1) begin
        fails++;
        $display("FAIL loop_done pkt=%0d count=%0d exp=1", p, pd_a - pd0);
      end
      checks++;
      if (got[671:64] !== v[671:64]) begin
        fails++;
        $display("FAIL loop_data pkt=%0d got=%h exp=%h", p,
                 got[671:600], v[671:600]);
      end
      checks++;
      if (got[63:32] !== v[63:32]) begin
        fails++;
        $display("FAIL loop_nonce pkt=%0d got=%h exp=%h", p,
                 got[63:32], v[63:32]);
      end
      checks++;
      if (got[31:0] !== v[31:0]) begin
        fails++;
        $display("FAIL loop_target pkt=%0d got=%h exp=%h", p,
                 got[31:0], v[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bit_timing();
    test_handshake();
    test_gap();
    test_reset_mid();
    test_loopback();
    checks++;
    if (frame_err !== 0) begin
      fails++;
      $display("FAIL framing errors=%0d exp=0", frame_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/work_packet_tx.md
Name: work_packet_tx

Overview:
- Host-side/bench-side UART serializer: the transmit end of the work-packet link into the miner's serial receiver.
- Accepts one work unit (608-bit header data, 32-bit start nonce, 32-bit target word) and frames it as 84 bytes of 8N1 UART on TxD.
- Used in the loopback test harness and in a future dual-FPGA controller that feeds miner boards.

Parameters:
- BAUD_DIV, 434, clocks per UART bit (50 MHz / 115200); legal range 2..65535.
- PKT_BYTES, 84, bytes per packet = (608+32+32)/8; fixed, never overridden.
- GAP_BITS, 0, idle bit-times (TxD=1) inserted after each stop bit; legal range 0..15.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  packet offered this cycle.
- pkt_ready  out  1  block can accept a packet.
- pkt_data  in  608  header data field.
- pkt_nonce  in  32  start nonce field.
- pkt_target1  in  32  target word field.
- TxD  out  1  UART line, idle high.
- busy  out  1  high from acceptance until the last stop/gap bit ends.
- byte_done  out  1  one-cycle pulse at the end of each byte's stop bit.
- pkt_done  out  1  one-cycle pulse at the end of the final byte (after its gap bits, if any).

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled by the system):
  - Outputs: TxD=1, busy=0, pkt_ready=1, byte_done=0, pkt_done=0.
  - Internal state: state=IDLE; all counters 0; the shift register contents are don't-care.
- Acceptance:
  - A packet is accepted on any rising edge where pkt_valid && pkt_ready.
  - On that edge the block latches {pkt_data, pkt_nonce, pkt_target1} into a 672-bit register, with pkt_data at [671:64], pkt_nonce at [63:32] and pkt_target1 at [31:0].
  - On the same edge: pkt_ready<=0 and busy<=1.
  - pkt_valid while pkt_ready=0 is ignored. There is no queueing.
- Byte order and bit order:
  - Byte 0 is reg[671:664] (MSB end first), byte 83 is reg[7:0].
  - Each byte is sent LSB-first.
- Bit timing:
  - Every bit-time lasts exactly BAUD_DIV clocks, counted by a 16-bit divider that reloads at every bit boundary.
  - The start bit of byte 0 is driven on TxD starting the cycle after acceptance, i.e. 1-cycle latency.
- FSM:
  - IDLE -> START on accept.
  - START (TxD=0, 1 bit-time) -> DATA.
  - DATA (8 bit-times, TxD = current LSB; the byte is shifted right each bit) -> STOP.
  - STOP (TxD=1, 1 bit-time) -> GAP if GAP_BITS>0, else next-byte decision.
  - GAP (TxD=1, GAP_BITS bit-times) -> next-byte decision.
  - Next-byte decision: if byte_cnt < PKT_BYTES-1, byte_cnt++ and go to START; otherwise go to IDLE.
- End-of-byte and end-of-packet outputs:
  - byte_done pulses on the last clock of every STOP bit-time.
  - pkt_done pulses on the last clock of the final byte's STOP bit-time, or of its GAP bit-time when GAP_BITS>0.
  - On the cycle after pkt_done: busy=0 and pkt_ready=1.
- Throughput:
  - Total packet time is PKT_BYTES*(10+GAP_BITS)*BAUD_DIV clocks, measured from the first start-bit clock.
  - Back-to-back packets: if pkt_valid is held high, the next acceptance happens the cycle pkt_ready returns to 1. The minimum idle on TxD between packets is therefore 1 clock plus GAP_BITS bit-times.
- Counters: byte_cnt is 7 bits and never exceeds 83; the bit counter is 4 bits. Neither counter wraps in legal operation.
- Reset mid-packet: TxD goes to 1 immediately (asynchronously), the packet is discarded, and no done pulse is generated. The receiving end resynchronises on its own idle timeout.
- TxD is driven from a register. It never glitches and is never combinational from state.

Test Plan:
- Single packet, BAUD_DIV=4, GAP_BITS=0, pkt_data=608'h0102...(byte i = i+1), pkt_nonce=32'hDEADBEEF, pkt_target1=32'h0000FFFF:
  - Decoded byte stream is 01,02,...,4C,DE,AD,BE,EF,00,00,FF,FF.
  - byte_done pulses 84 times; pkt_done pulses once, 3360 clocks after the first start bit.
- Bit timing, BAUD_DIV=4, first byte 8'hA5:
  - TxD sequence, sampled every 4 clocks from the cycle after accept, is 0,1,0,1,0,0,1,0,1,1.
  - Each level is held exactly 4 clocks.
- Handshake:
  - pkt_valid held high with new content (nonce 32'h00000001) during busy: no effect, and the first packet transmits unchanged.
  - The second packet is accepted the cycle pkt_ready returns to 1, and its start bit begins on the next cycle.
- GAP_BITS=2, BAUD_DIV=4:
  - TxD=1 for 8 clocks after each stop bit.
  - The total packet takes 84*12*4=4032 clocks.
  - pkt_done pulses at the end of the last gap.
- Reset mid-packet: assert rst_n=0 during DATA of byte 10.
  - TxD=1, busy=0, pkt_ready=1 without waiting for a clock edge.
  - No pkt_done pulse.
  - A new packet after deassertion transmits from byte 0 correctly.
- Loopback: TxD drives the miner's serial receiver at BAUD_DIV=434.
  - The receiver's is_last pulses once.
  - Its data, nonce and target1 outputs equal the sent fields bit-for-bit.
